// File: rtl/nn_buf_pkg.sv
// nn_buf_pkg
// Shared helpers and types for the NN buffer blocks.
//   ch_w(n)     : channel-index width, never less than one bit
//   is_pow2(n)  : elaboration-time parameter sanity check
//   buf_role_e  : scheduler's default channel assignment when NUM_CH = 4
package nn_buf_pkg;

  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

  typedef enum logic [1:0] {
    BUF_IN_DATA  = 2'd0,
    BUF_WEIGHT   = 2'd1,
    BUF_BIAS     = 2'd2,
    BUF_OUT_DATA = 2'd3
  } buf_role_e;

endpackage

// File: rtl/ring_ptr_ctrl.sv
// ring_ptr_ctrl
// Pointer and occupancy bookkeeping for one circular buffer channel.
// Ports:
//   clk, rstn          : clock, synchronous active-low reset
//   push, pop          : accepted write / read this cycle (already qualified)
//   flush              : clear this channel on the next edge
//   wr_ptr, rd_ptr     : AW-bit pointers, wrap naturally at DEPTH
//   usage              : occupancy 0..DEPTH
//   full, empty        : usage == DEPTH / usage == 0
//   refill_req         : usage <= LOW_WATER
module ring_ptr_ctrl #(
  parameter int DEPTH     = 64,
  parameter int LOW_WATER = 16,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  output logic [AW-1:0] wr_ptr,
  output logic [AW-1:0] rd_ptr,
  output logic [AW:0]   usage,
  output logic          full,
  output logic          empty,
  output logic          refill_req
);

  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   USE_ONE = (AW + 1)'(1);

  // Flush has the same effect as reset for this channel; the top already
  // refuses traffic to a flushing channel, so push/pop are low then anyway.
  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      usage  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   usage <= usage + USE_ONE;
        2'b01:   usage <= usage - USE_ONE;
        default: usage <= usage;
      endcase
    end
  end

  assign full       = (usage == (AW + 1)'(DEPTH));
  assign empty      = (usage == '0);
  assign refill_req = (usage <= (AW + 1)'(LOW_WATER));

endmodule

// File: rtl/multi_ring_buffer.sv
// multi_ring_buffer
// NUM_CH independent circular buffers sharing one storage array, with a
// single channel-steered write port and a single channel-steered read port.
// Ports:
//   clk, rstn                 : clock, synchronous active-low reset
//   wr_valid, wr_ch, wr_data  : write request; wr_ready = accepted this cycle
//   rd_valid, rd_ch           : read request;  rd_ready = accepted this cycle
//   rd_data, rd_data_valid    : read payload one cycle after acceptance
//   flush                     : per-channel clear
//   usage                     : packed per-channel occupancy, AW+1 bits each
//   full, empty, refill_req   : per-channel status from registered usage
module multi_ring_buffer
  import nn_buf_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 4,
  parameter int DEPTH      = 64,
  parameter int LOW_WATER  = 16,
  localparam int CH_W      = ch_w(NUM_CH),
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     wr_valid,
  input  logic [CH_W-1:0]          wr_ch,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  output logic                     wr_ready,
  input  logic                     rd_valid,
  input  logic [CH_W-1:0]          rd_ch,
  output logic                     rd_ready,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     rd_data_valid,
  input  logic [NUM_CH-1:0]        flush,
  output logic [NUM_CH*(AW+1)-1:0] usage,
  output logic [NUM_CH-1:0]        full,
  output logic [NUM_CH-1:0]        empty,
  output logic [NUM_CH-1:0]        refill_req
);

  if (NUM_CH < 1) begin : g_bad_num_ch
    $error("multi_ring_buffer: NUM_CH must be >= 1");
  end
  if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
    $error("multi_ring_buffer: DEPTH must be a power of two >= 2");
  end
  if (LOW_WATER >= DEPTH) begin : g_bad_low_water
    $error("multi_ring_buffer: LOW_WATER must be < DEPTH");
  end

  logic [DATA_WIDTH-1:0] mem [NUM_CH*DEPTH];

  logic [AW-1:0]     wr_ptr_a [NUM_CH];
  logic [AW-1:0]     rd_ptr_a [NUM_CH];
  logic [AW:0]       usage_a  [NUM_CH];
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;

  // Full/empty come from registered usage only, so a same-cycle read never
  // frees room for a write and a same-cycle write never feeds a read.
  assign wr_ready = wr_valid & ~full[wr_ch] & ~flush[wr_ch];
  assign rd_ready = rd_valid & ~empty[rd_ch] & ~flush[rd_ch];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign push[g] = wr_ready && (wr_ch == CH_W'(g));
    assign pop[g]  = rd_ready && (rd_ch == CH_W'(g));

    ring_ptr_ctrl #(
      .DEPTH     (DEPTH),
      .LOW_WATER (LOW_WATER)
    ) u_ptr (
      .clk        (clk),
      .rstn       (rstn),
      .push       (push[g]),
      .pop        (pop[g]),
      .flush      (flush[g]),
      .wr_ptr     (wr_ptr_a[g]),
      .rd_ptr     (rd_ptr_a[g]),
      .usage      (usage_a[g]),
      .full       (full[g]),
      .empty      (empty[g]),
      .refill_req (refill_req[g])
    );

    assign usage[g*(AW+1) +: AW+1] = usage_a[g];
  end

  // Storage is never reset; the channel index forms the upper address bits.
  always_ff @(posedge clk) begin
    if (wr_ready) mem[{wr_ch, wr_ptr_a[wr_ch]}] <= wr_data;
  end

  // Registered read port: data appears one cycle after acceptance and holds
  // its last value while rd_data_valid is low.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_data       <= '0;
      rd_data_valid <= 1'b0;
    end else begin
      rd_data_valid <= rd_ready;
      if (rd_ready) rd_data <= mem[{rd_ch, rd_ptr_a[rd_ch]}];
    end
  end

endmodule
